// File: rtl/mc_maindec_pkg.sv
// Shared types and constants for the multicycle main control FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    OP_NOOP = 4'b0000,
    OP_JR   = 4'b0001,
    OP_JI   = 4'b0010,
    OP_BE   = 4'b0011,
    OP_SW   = 4'b0101,
    OP_MFLO = 4'b0110,
    OP_LW   = 4'b0111,
    OP_LI   = 4'b1000,
    OP_ADD  = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_AND  = 4'b1011,
    OP_OR   = 4'b1100,
    OP_MULT = 4'b1101,
    OP_SLL  = 4'b1110,
    OP_SLR  = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_MULT,
    S_TRAP
  } state_t;

  localparam logic [1:0] PCSRC_PC1 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JI  = 2'b10;
  localparam logic [1:0] PCSRC_REG = 2'b11;

  localparam int MUL_CYCLES_DEF = 4;

  // Register-register ALU operations that write rd.
  function automatic logic is_rtype(input opcode_t o);
    return (o == OP_ADD) || (o == OP_XOR) || (o == OP_AND) ||
           (o == OP_OR)  || (o == OP_SLL) || (o == OP_SLR);
  endfunction

endpackage

// File: rtl/mc_maindec_if.sv
// Control bundle between the instruction register / datapath and the main FSM.
interface mc_maindec_if #(parameter int OPW = 4);
  logic [OPW-1:0] op;
  logic           zero;
  logic           mem_ready;
  logic           memread;
  logic           memwrite;
  logic           iord;
  logic           irwrite;
  logic           pcwrite;
  logic [1:0]     pcsrc;
  logic           alusrc;
  logic           regdst;
  logic           regwrite;
  logic           mem2reg;
  logic           lo2reg;
  logic           hilowrite;
  logic           instr_done;
  logic           illegal;

  // Controller side: consumes opcode and status, drives the enables.
  modport master (
    input  op, zero, mem_ready,
    output memread, memwrite, iord, irwrite, pcwrite, pcsrc,
           alusrc, regdst, regwrite, mem2reg, lo2reg, hilowrite,
           instr_done, illegal
  );

  // Datapath side: the mirror image.
  modport slave (
    output op, zero, mem_ready,
    input  memread, memwrite, iord, irwrite, pcwrite, pcsrc,
           alusrc, regdst, regwrite, mem2reg, lo2reg, hilowrite,
           instr_done, illegal
  );
endinterface

// File: rtl/mc_maindec_mul_timer.sv
// Cycle counter that marks the final cycle of a multi-cycle multiply.
module mul_timer
  import mc_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority so a new multiply always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main control FSM: fetch/decode/exec/mem/wb sequencing with
// memory-ready stalls, a timed MULT state and a sticky illegal-opcode trap.
module mc_maindec
  import mc_pkg::*;
#(
  parameter int OPW        = 4,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mc_maindec_if.master  bus
);

  state_t  state_q, state_d;
  opcode_t opc;
  logic    upper_nz;
  logic    legal;
  logic    mul_clear, mul_en, mul_last;

  assign opc = opcode_t'(bus.op[3:0]);

  generate
    if (OPW > 4) begin : g_wide
      assign upper_nz = |bus.op[OPW-1:4];
    end else begin : g_narrow
      assign upper_nz = 1'b0;
    end
  endgenerate

  assign legal = !upper_nz && (bus.op[3:0] != 4'b0100);

  // Counter restarts on the DECODE->MULT transition and runs only in MULT.
  assign mul_clear = (state_q == S_DECODE) && (state_d == S_MULT);
  assign mul_en    = (state_q == S_MULT);

  mul_timer #(.MUL_CYCLES(MUL_CYCLES)) u_mul_timer (
    .clk   (clk),
    .reset (reset),
    .clear (mul_clear),
    .en    (mul_en),
    .last  (mul_last)
  );

  // State register; reset returns to FETCH from any state, including TRAP.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control outputs from state, opcode, zero and mem_ready.
  always_comb begin
    state_d        = state_q;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.pcsrc      = PCSRC_PC1;
    bus.alusrc     = 1'b0;
    bus.regdst     = 1'b0;
    bus.regwrite   = 1'b0;
    bus.mem2reg    = 1'b0;
    bus.lo2reg     = 1'b0;
    bus.hilowrite  = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcwrite = 1'b1;
          state_d     = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!legal)                 state_d = S_TRAP;
        else if (opc == OP_NOOP) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        else if (opc == OP_MULT)    state_d = S_MULT;
        else                        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_WB;
        case (opc)
          OP_JR: begin
            bus.pcwrite    = 1'b1;
            bus.pcsrc      = PCSRC_REG;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
          OP_JI: begin
            bus.pcwrite    = 1'b1;
            bus.pcsrc      = PCSRC_JI;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
          OP_BE: begin
            bus.pcwrite    = bus.zero;
            bus.pcsrc      = PCSRC_BR;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
          OP_LW, OP_SW: begin
            bus.alusrc = 1'b1;
            state_d    = S_MEM;
          end
          OP_LI:   bus.alusrc = 1'b1;
          default: bus.alusrc = 1'b0;
        endcase
      end

      S_MEM: begin
        bus.iord     = 1'b1;
        bus.memread  = (opc == OP_LW);
        bus.memwrite = (opc == OP_SW);
        if (bus.mem_ready) begin
          if (opc == OP_SW) begin
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
        bus.regdst     = is_rtype(opc);
        bus.mem2reg    = (opc == OP_LW);
        bus.lo2reg     = (opc == OP_MFLO);
        state_d        = S_FETCH;
      end

      S_MULT: begin
        if (mul_last) begin
          bus.hilowrite  = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end

      S_TRAP: begin
        bus.illegal = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec: per-cycle check of the packed control vector.
module tb_mc_maindec;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_maindec_if #(.OPW(4)) bus4 ();
  mc_maindec_if #(.OPW(8)) bus8 ();

  mc_maindec #(.OPW(4), .MUL_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.master));
  mc_maindec #(.OPW(8), .MUL_CYCLES(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8.master));

  // Packed order: memread memwrite iord irwrite pcwrite pcsrc[1:0] alusrc
  //               regdst regwrite mem2reg lo2reg hilowrite instr_done illegal
  logic [14:0] o4, o8;
  assign o4 = {bus4.memread, bus4.memwrite, bus4.iord, bus4.irwrite, bus4.pcwrite,
               bus4.pcsrc, bus4.alusrc, bus4.regdst, bus4.regwrite, bus4.mem2reg,
               bus4.lo2reg, bus4.hilowrite, bus4.instr_done, bus4.illegal};
  assign o8 = {bus8.memread, bus8.memwrite, bus8.iord, bus8.irwrite, bus8.pcwrite,
               bus8.pcsrc, bus8.alusrc, bus8.regdst, bus8.regwrite, bus8.mem2reg,
               bus8.lo2reg, bus8.hilowrite, bus8.instr_done, bus8.illegal};

  localparam logic [14:0] F_WAIT  = 15'h4000; // memread
  localparam logic [14:0] F_RDY   = 15'h4C00; // memread irwrite pcwrite
  localparam logic [14:0] NONE    = 15'h0000;
  localparam logic [14:0] ND      = 15'h0002; // instr_done only
  localparam logic [14:0] EX_IMM  = 15'h0080; // alusrc
  localparam logic [14:0] EX_JR   = 15'h0702; // pcwrite pcsrc=11 done
  localparam logic [14:0] EX_JI   = 15'h0602; // pcwrite pcsrc=10 done
  localparam logic [14:0] EX_BE0  = 15'h0102; // pcsrc=01 done
  localparam logic [14:0] EX_BE1  = 15'h0502; // pcwrite pcsrc=01 done
  localparam logic [14:0] MEM_LW  = 15'h5000; // memread iord
  localparam logic [14:0] MEM_SW  = 15'h3002; // memwrite iord done
  localparam logic [14:0] WB_R    = 15'h0062; // regdst regwrite done
  localparam logic [14:0] WB_LW   = 15'h0032; // regwrite mem2reg done
  localparam logic [14:0] WB_LI   = 15'h0022; // regwrite done
  localparam logic [14:0] WB_LO   = 15'h002A; // regwrite lo2reg done
  localparam logic [14:0] MUL_END = 15'h0006; // hilowrite done
  localparam logic [14:0] TRAPV   = 15'h0001; // illegal

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [14:0] act, input logic [14:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, check on the falling edge, step past the rising edge.
  task automatic cyc(input string tag, input logic [7:0] o, input logic rdy,
                     input logic zr, input logic [14:0] exp, input bit wide);
    bus4.op        = o[3:0];
    bus8.op        = o;
    bus4.mem_ready = rdy;
    bus8.mem_ready = rdy;
    bus4.zero      = zr;
    bus8.zero      = zr;
    @(negedge clk);
    if (wide) chk(tag, o8, exp);
    else      chk(tag, o4, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus4.op = '0; bus8.op = '0;
    bus4.zero = 1'b0; bus8.zero = 1'b0;
    bus4.mem_ready = 1'b0; bus8.mem_ready = 1'b0;
    do_reset();

    // Reset state, then a FETCH stall
    cyc("rst_fetch", 8'h09, 1'b0, 1'b0, F_WAIT, 0);

    // ADD: 4 cycles, mem_ready ignored in DECODE
    cyc("add_c1", 8'h09, 1'b1, 1'b0, F_RDY,  0);
    cyc("add_c2", 8'h09, 1'b0, 1'b0, NONE,   0);
    cyc("add_c3", 8'h09, 1'b0, 1'b0, NONE,   0);
    cyc("add_c4", 8'h09, 1'b1, 1'b0, WB_R,   0);

    // LW with three MEM stall cycles: 8 cycles
    cyc("lw_c1", 8'h07, 1'b1, 1'b0, F_RDY,  0);
    cyc("lw_c2", 8'h07, 1'b1, 1'b0, NONE,   0);
    cyc("lw_c3", 8'h07, 1'b1, 1'b0, EX_IMM, 0);
    cyc("lw_c4", 8'h07, 1'b0, 1'b0, MEM_LW, 0);
    cyc("lw_c5", 8'h07, 1'b0, 1'b0, MEM_LW, 0);
    cyc("lw_c6", 8'h07, 1'b0, 1'b0, MEM_LW, 0);
    cyc("lw_c7", 8'h07, 1'b1, 1'b0, MEM_LW, 0);
    cyc("lw_c8", 8'h07, 1'b1, 1'b0, WB_LW,  0);

    // BE not taken, then taken
    cyc("be0_c1", 8'h03, 1'b1, 1'b0, F_RDY,  0);
    cyc("be0_c2", 8'h03, 1'b1, 1'b0, NONE,   0);
    cyc("be0_c3", 8'h03, 1'b1, 1'b0, EX_BE0, 0);
    cyc("be1_c1", 8'h03, 1'b1, 1'b1, F_RDY,  0);
    cyc("be1_c2", 8'h03, 1'b1, 1'b1, NONE,   0);
    cyc("be1_c3", 8'h03, 1'b1, 1'b1, EX_BE1, 0);

    // JR, JI
    cyc("jr_c1", 8'h01, 1'b1, 1'b0, F_RDY, 0);
    cyc("jr_c2", 8'h01, 1'b1, 1'b0, NONE,  0);
    cyc("jr_c3", 8'h01, 1'b1, 1'b0, EX_JR, 0);
    cyc("ji_c1", 8'h02, 1'b1, 1'b0, F_RDY, 0);
    cyc("ji_c2", 8'h02, 1'b1, 1'b0, NONE,  0);
    cyc("ji_c3", 8'h02, 1'b1, 1'b0, EX_JI, 0);

    // LI, MFLO
    cyc("li_c1", 8'h08, 1'b1, 1'b0, F_RDY,  0);
    cyc("li_c2", 8'h08, 1'b1, 1'b0, NONE,   0);
    cyc("li_c3", 8'h08, 1'b1, 1'b0, EX_IMM, 0);
    cyc("li_c4", 8'h08, 1'b1, 1'b0, WB_LI,  0);
    cyc("lo_c1", 8'h06, 1'b1, 1'b0, F_RDY,  0);
    cyc("lo_c2", 8'h06, 1'b1, 1'b0, NONE,   0);
    cyc("lo_c3", 8'h06, 1'b1, 1'b0, NONE,   0);
    cyc("lo_c4", 8'h06, 1'b1, 1'b0, WB_LO,  0);

    // SW then NOOP back to back
    cyc("sw_c1", 8'h05, 1'b1, 1'b0, F_RDY,  0);
    cyc("sw_c2", 8'h05, 1'b1, 1'b0, NONE,   0);
    cyc("sw_c3", 8'h05, 1'b1, 1'b0, EX_IMM, 0);
    cyc("sw_c4", 8'h05, 1'b1, 1'b0, MEM_SW, 0);
    cyc("nop_c1", 8'h00, 1'b1, 1'b0, F_RDY, 0);
    cyc("nop_c2", 8'h00, 1'b1, 1'b0, ND,    0);

    // MULT, MUL_CYCLES=4: 6 cycles, hilowrite in cycle 6 only
    cyc("mul_c1", 8'h0D, 1'b1, 1'b0, F_RDY,   0);
    cyc("mul_c2", 8'h0D, 1'b1, 1'b0, NONE,    0);
    cyc("mul_c3", 8'h0D, 1'b0, 1'b0, NONE,    0);
    cyc("mul_c4", 8'h0D, 1'b0, 1'b0, NONE,    0);
    cyc("mul_c5", 8'h0D, 1'b1, 1'b0, NONE,    0);
    cyc("mul_c6", 8'h0D, 1'b1, 1'b0, MUL_END, 0);

    // MULT aborted by reset in cycle 4
    cyc("mab_c1", 8'h0D, 1'b1, 1'b0, F_RDY, 0);
    cyc("mab_c2", 8'h0D, 1'b1, 1'b0, NONE,  0);
    cyc("mab_c3", 8'h0D, 1'b1, 1'b0, NONE,  0);
    reset = 1'b1;
    cyc("mab_c4", 8'h0D, 1'b1, 1'b0, NONE,  0);
    reset = 1'b0;
    cyc("mab_fetch0", 8'h0D, 1'b0, 1'b0, F_WAIT, 0);
    cyc("mab_fetch1", 8'h0D, 1'b0, 1'b0, F_WAIT, 0);
    cyc("mab_fetch2", 8'h0D, 1'b0, 1'b0, F_WAIT, 0);

    // Illegal 0100 on OPW=4: trap holds for 10 cycles until reset
    cyc("ill4_c1", 8'h04, 1'b1, 1'b0, F_RDY, 0);
    cyc("ill4_c2", 8'h04, 1'b1, 1'b0, NONE,  0);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("ill4_trap%0d", i), 8'h04, 1'(i), 1'(i >> 1), TRAPV, 0);
    reset = 1'b1;
    cyc("ill4_rst", 8'h04, 1'b1, 1'b0, TRAPV, 0);
    reset = 1'b0;
    cyc("ill4_clr", 8'h04, 1'b0, 1'b0, F_WAIT, 0);

    // Opcode 0x11 on OPW=8: low nibble is JR but upper bits make it illegal
    do_reset();
    cyc("ill8_c1", 8'h11, 1'b1, 1'b0, F_RDY, 1);
    cyc("ill8_c2", 8'h11, 1'b1, 1'b0, NONE,  1);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("ill8_trap%0d", i), 8'h11, 1'(i), 1'b1, TRAPV, 1);
    reset = 1'b1;
    cyc("ill8_rst", 8'h11, 1'b1, 1'b0, TRAPV, 1);
    reset = 1'b0;
    cyc("ill8_clr", 8'h11, 1'b0, 1'b0, F_WAIT, 1);

    // Legal ADD on the wide instance after the trap is cleared
    cyc("add8_c1", 8'h09, 1'b1, 1'b0, F_RDY, 1);
    cyc("add8_c2", 8'h09, 1'b1, 1'b0, NONE,  1);
    cyc("add8_c3", 8'h09, 1'b1, 1'b0, NONE,  1);
    cyc("add8_c4", 8'h09, 1'b1, 1'b0, WB_R,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
